// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage constants: ALU operation codes, instruction classes and control decode.
package mips_pkg;

   localparam int unsigned ALU_CTRL_W = 4;
   localparam int unsigned ALU_OP_W   = 2;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b1000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1001;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1011;
   localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 4'b1100;

   localparam logic [ALU_OP_W-1:0] OP_LOAD  = 2'd0;
   localparam logic [ALU_OP_W-1:0] OP_STORE = 2'd1;
   localparam logic [ALU_OP_W-1:0] OP_ALU   = 2'd2;
   localparam logic [ALU_OP_W-1:0] OP_NONE  = 2'd3;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_write;
   } ex_ctrl_t;

   // Writeback/memory controls implied by the instruction class.
   function automatic ex_ctrl_t decode_op(input logic [ALU_OP_W-1:0] op);
      ex_ctrl_t c;
      c = '0;
      case (op)
         OP_LOAD:  c = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0};
         OP_STORE: c = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b1};
         OP_ALU:   c = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_write: 1'b0};
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational MIPS ALU; shifts take their amount from the low bits of operand A.
module mips_alu
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   input  logic [ALU_CTRL_W-1:0] ctrl_i,
   output logic [DATA_W-1:0]     result_o,
   output logic                  zero_o
);

   localparam int unsigned SHAMT_W = $clog2(DATA_W);

   logic [SHAMT_W-1:0] shamt;
   assign shamt = a_i[SHAMT_W-1:0];

   always_comb begin
      result_o = '0;
      case (ctrl_i)
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_ADD:  result_o = a_i + b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_NOR:  result_o = ~(a_i | b_i);
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SLT:  result_o = DATA_W'($signed(a_i) < $signed(b_i));
         ALU_SLTU: result_o = DATA_W'(a_i < b_i);
         ALU_SLL:  result_o = b_i << shamt;
         ALU_SRL:  result_o = b_i >> shamt;
         ALU_SRA:  result_o = DATA_W'($signed(b_i) >>> shamt);
         ALU_LUI:  result_o = b_i << 16;
         default:  result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/mips_execute_stage.sv
// MIPS EX stage: operand/destination muxing, ALU, control decode and the EX/MEM register.
module mips_execute_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ALU_CTRL_W-1:0] ALUControlE,
   input  logic [ALU_OP_W-1:0]   ALUOpE,
   input  logic                  ALUSrcE,
   input  logic                  RegDstE,
   input  logic [DATA_W-1:0]     SignImmE,
   input  logic [REG_AW-1:0]     RsE,
   input  logic [REG_AW-1:0]     RtE,
   input  logic [REG_AW-1:0]     RdE,
   input  logic [DATA_W-1:0]     value1,
   input  logic [DATA_W-1:0]     value2,
   output logic                  RegWriteE,
   output logic                  MemToRegE,
   output logic                  MemWriteE,
   output logic [REG_AW-1:0]     writeRegE,
   output logic [DATA_W-1:0]     AluOutE,
   output logic [DATA_W-1:0]     WriteDataE,
   output logic                  ZeroE
);

   // Rs is carried only for a future forwarding unit.
   logic unused_rs;
   assign unused_rs = ^RsE;

   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   ex_ctrl_t          ctrl_d,      ctrl_q;
   logic [REG_AW-1:0] write_reg_d, write_reg_q;
   logic [DATA_W-1:0] alu_out_q,   write_data_q;
   logic              zero_q;

   mips_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i      (value1),
      .b_i      (src_b),
      .ctrl_i   (ALUControlE),
      .result_o (alu_result),
      .zero_o   (alu_zero)
   );

   always_comb begin
      src_b       = ALUSrcE ? SignImmE : value2;
      write_reg_d = RegDstE ? RdE : RtE;
      ctrl_d      = decode_op(ALUOpE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q       <= '0;
         write_reg_q  <= '0;
         alu_out_q    <= '0;
         write_data_q <= '0;
         zero_q       <= 1'b0;
      end else begin
         ctrl_q       <= ctrl_d;
         write_reg_q  <= write_reg_d;
         alu_out_q    <= alu_result;
         write_data_q <= value2;
         zero_q       <= alu_zero;
      end
   end

   assign RegWriteE  = ctrl_q.reg_write;
   assign MemToRegE  = ctrl_q.mem_to_reg;
   assign MemWriteE  = ctrl_q.mem_write;
   assign writeRegE  = write_reg_q;
   assign AluOutE    = alu_out_q;
   assign WriteDataE = write_data_q;
   assign ZeroE      = zero_q;

endmodule

// File: tb/tb_mips_execute_stage.sv
// Directed self-checking bench for mips_execute_stage with hand-computed expectations.
module tb_mips_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ALUControlE;
   logic [1:0]  ALUOpE;
   logic        ALUSrcE, RegDstE;
   logic [31:0] SignImmE, value1, value2;
   logic [4:0]  RsE, RtE, RdE;
   logic        RegWriteE, MemToRegE, MemWriteE, ZeroE;
   logic [4:0]  writeRegE;
   logic [31:0] AluOutE, WriteDataE;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_execute_stage dut (
      .clk(clk), .rst(rst),
      .ALUControlE(ALUControlE), .ALUOpE(ALUOpE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
      .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
      .value1(value1), .value2(value2),
      .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
      .writeRegE(writeRegE), .AluOutE(AluOutE), .WriteDataE(WriteDataE), .ZeroE(ZeroE)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ctl, input logic [1:0] op, input logic src,
                        input logic dst, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
      ALUControlE = ctl; ALUOpE = op; ALUSrcE = src; RegDstE = dst;
      value1 = v1; value2 = v2; SignImmE = imm; RtE = rt; RdE = rd;
      RsE = 5'(v1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctrl(input string tag, input logic [2:0] exp);
      check(tag, 32'({RegWriteE, MemToRegE, MemWriteE}), 32'(exp));
   endtask

   initial begin
      // Reset with arbitrary live inputs
      rst = 1'b1;
      drive(4'b0010, 2'd0, 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001, 5'd7, 5'd9);
      step();
      check("rst_aluout", AluOutE, 32'h0);
      check("rst_zero", 32'(ZeroE), 32'h0);
      check("rst_wreg", 32'(writeRegE), 32'h0);
      check("rst_wdata", WriteDataE, 32'h0);
      check_ctrl("rst_ctrl", 3'b000);

      // Unused op code on the first non-reset edge
      rst = 1'b0;
      drive(4'b1111, 2'd1, 1'b0, 1'b1, 32'd10, 32'd12, 32'd100, 5'd1, 5'd3);
      step();
      check("unused_aluout", AluOutE, 32'h0);
      check("unused_zero", 32'(ZeroE), 32'h1);
      check("unused_wreg", 32'(writeRegE), 32'd3);
      check("unused_wdata", WriteDataE, 32'd12);
      check_ctrl("unused_ctrl", 3'b001);

      // Immediate ADD as a load; outputs must hold until the edge
      drive(4'b0010, 2'd0, 1'b1, 1'b0, 32'd10, 32'd12, 32'd100, 5'd1, 5'd3);
      #2;
      check("latency_hold", AluOutE, 32'h0);
      step();
      check("addi_aluout", AluOutE, 32'd110);
      check("addi_wreg", 32'(writeRegE), 32'd1);
      check("addi_zero", 32'(ZeroE), 32'h0);
      check("addi_wdata", WriteDataE, 32'd12);
      check_ctrl("addi_ctrl", 3'b110);

      drive(4'b0110, 2'd3, 1'b0, 1'b1, 32'd12, 32'd12, 32'd5, 5'd4, 5'd6);
      step();
      check("sub_aluout", AluOutE, 32'h0);
      check("sub_zero", 32'(ZeroE), 32'h1);
      check("sub_wreg", 32'(writeRegE), 32'd6);
      check_ctrl("sub_ctrl", 3'b000);

      drive(4'b0110, 2'd2, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0, 5'd2, 5'd3);
      step();
      check("sub_wrap", AluOutE, 32'hFFFF_FFFF);
      check_ctrl("alu_ctrl", 3'b100);

      drive(4'b0010, 2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2, 5'd3);
      step();
      check("add_wrap", AluOutE, 32'h0);
      check("add_wrap_zero", 32'(ZeroE), 32'h1);

      // Signed versus unsigned compare on consecutive cycles
      drive(4'b0111, 2'd2, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd2, 5'd3);
      step();
      check("slt", AluOutE, 32'd1);
      check("slt_zero", 32'(ZeroE), 32'h0);
      drive(4'b1011, 2'd2, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd2, 5'd3);
      step();
      check("sltu", AluOutE, 32'd0);
      check("sltu_zero", 32'(ZeroE), 32'h1);

      // Shifts, back to back
      drive(4'b1000, 2'd2, 1'b0, 1'b0, 32'd4, 32'hF000_0000, 32'd0, 5'd2, 5'd3);
      step();
      check("sll", AluOutE, 32'h0000_0000);
      drive(4'b1001, 2'd2, 1'b0, 1'b0, 32'd4, 32'hF000_0000, 32'd0, 5'd2, 5'd3);
      step();
      check("srl", AluOutE, 32'h0F00_0000);
      drive(4'b1010, 2'd2, 1'b0, 1'b0, 32'd4, 32'hF000_0000, 32'd0, 5'd2, 5'd3);
      step();
      check("sra", AluOutE, 32'hFF00_0000);
      drive(4'b1001, 2'd2, 1'b0, 1'b0, 32'h0000_0024, 32'hF000_0000, 32'd0, 5'd2, 5'd3);
      step();
      check("srl_shamt_lowbits", AluOutE, 32'h0F00_0000);
      drive(4'b1000, 2'd2, 1'b0, 1'b0, 32'd31, 32'd1, 32'd0, 5'd2, 5'd3);
      step();
      check("sll31", AluOutE, 32'h8000_0000);
      drive(4'b1010, 2'd2, 1'b0, 1'b0, 32'd31, 32'h8000_0000, 32'd0, 5'd2, 5'd3);
      step();
      check("sra31", AluOutE, 32'hFFFF_FFFF);

      drive(4'b1100, 2'd2, 1'b1, 1'b0, 32'd0, 32'hAAAA_AAAA, 32'h0000_1234, 5'd8, 5'd3);
      step();
      check("lui", AluOutE, 32'h1234_0000);
      check("lui_wdata", WriteDataE, 32'hAAAA_AAAA);
      check("lui_wreg", 32'(writeRegE), 32'd8);

      // Logic ops
      drive(4'b0000, 2'd2, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd2, 5'd3);
      step();
      check("and", AluOutE, 32'h0000_F000);
      drive(4'b0001, 2'd2, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd2, 5'd3);
      step();
      check("or", AluOutE, 32'h0000_FFF0);
      drive(4'b0011, 2'd2, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd2, 5'd3);
      step();
      check("xor", AluOutE, 32'h0000_0FF0);
      drive(4'b0100, 2'd2, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd2, 5'd3);
      step();
      check("nor", AluOutE, 32'hFFFF_000F);
      drive(4'b0101, 2'd1, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd2, 5'd3);
      step();
      check("op0101", AluOutE, 32'h0);
      check_ctrl("store_ctrl", 3'b001);
      check("store_wreg", 32'(writeRegE), 32'd2);

      // Reset dominates live inputs, then the next edge loads
      drive(4'b0010, 2'd0, 1'b0, 1'b1, 32'd1, 32'd1, 32'd0, 5'd2, 5'd5);
      rst = 1'b1;
      step();
      check("rst2_aluout", AluOutE, 32'h0);
      check("rst2_zero", 32'(ZeroE), 32'h0);
      check("rst2_wreg", 32'(writeRegE), 32'h0);
      check("rst2_wdata", WriteDataE, 32'h0);
      check_ctrl("rst2_ctrl", 3'b000);
      rst = 1'b0;
      step();
      check("post_rst_aluout", AluOutE, 32'd2);
      check("post_rst_wreg", 32'(writeRegE), 32'd5);
      check("post_rst_wdata", WriteDataE, 32'd1);
      check_ctrl("post_rst_ctrl", 3'b110);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_execute_stage.md
Name: mips_execute_stage

Overview:
- Execute (EX) stage of the 5-stage MIPS pipeline; sits between the ID/EX operand inputs and the EX/MEM pipeline register.
- Selects ALU operand B and performs the ALU operation.
- Selects the destination register and decodes writeback/memory control from the op class.
- Registers all results into the EX/MEM boundary on the rising clock edge.

Parameters:
- DATA_W, 32, datapath/operand width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  system clock; rising edge active.
- rst  in  1  synchronous, active-high reset.
- ALUControlE  in  4  ALU operation select.
- ALUOpE  in  2  instruction class: 0 load, 1 store, 2 reg-writing ALU op, 3 no-writeback (branch/nop).
- ALUSrcE  in  1  1: SrcB = SignImmE; 0: SrcB = value2.
- RegDstE  in  1  1: destination = RdE; 0: destination = RtE.
- SignImmE  in  DATA_W  sign-extended immediate.
- RsE  in  REG_AW  source register index; reserved for forwarding; no functional effect.
- RtE  in  REG_AW  rt index.
- RdE  in  REG_AW  rd index.
- value1  in  DATA_W  operand A (rs data).
- value2  in  DATA_W  rt data.
- RegWriteE  out  1  registered register-file write enable.
- MemToRegE  out  1  registered writeback-from-memory select.
- MemWriteE  out  1  registered data-memory write enable.
- writeRegE  out  REG_AW  registered destination register index.
- AluOutE  out  DATA_W  registered ALU result.
- WriteDataE  out  DATA_W  registered store data (= value2).
- ZeroE  out  1  registered flag, 1 when ALU result == 0.

Behaviour:
- All outputs are flops updated on posedge clk; latency 1 cycle from input to output.
- No handshake; a new operation is accepted every cycle.
- rst=1 at a posedge clears every output to 0. ZeroE resets to 0, not 1.
- Reset dominates any inputs present in the same cycle; the next non-reset edge loads normally.
- Operand mux: SrcA = value1; SrcB = ALUSrcE ? SignImmE : value2.
- Destination mux: writeReg = RegDstE ? RdE : RtE.
- ALUControlE encoding; all arithmetic is modulo 2^32 and no overflow trap exists:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR.
  - 0110 SUB (A-B).
  - 0111 SLT signed, result 1 or 0.
  - 1011 SLTU unsigned, result 1 or 0.
  - 1000 SLL: B << A[4:0]; 1001 SRL: B >> A[4:0] logical; 1010 SRA: B >>> A[4:0] arithmetic.
  - 1100 LUI: B << 16.
  - 0101, 1101, 1110, 1111: result 0.
- Shift amount uses only A[4:0]; a shift of 31 is legal. SLT on 0x80000000 vs 1 gives 1; SLTU on the same operands gives 0.
- Control decode from ALUOpE, as {RegWrite, MemToReg, MemWrite}: 0 -> 110; 1 -> 001; 2 -> 100; 3 -> 000.
- writeRegE is registered regardless of RegWrite; downstream stages qualify it with RegWriteE.
- WriteDataE always carries value2, independent of ALUSrcE.
- ZeroE = (ALU result == 0), computed from the same cycle's result.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI).
  - ALUOp class constants (OP_LOAD, OP_STORE, OP_ALU, OP_NONE).
- One combinational sub-module, mips_alu: inputs A, B, ctrl; outputs result and zero.
- Muxes, control decode and the EX/MEM flops stay in the top module.

Test Plan:
- Reset: rst=1 with arbitrary inputs, one edge -> all outputs 0; deassert rst -> next edge loads the inputs.
- Unused op: ALUControl=1111, ALUSrc=0, RegDst=1, Rt=1, Rd=3, value1=10, value2=12, SignImm=100, ALUOp=1 -> after one edge: AluOut=0, Zero=1, writeReg=3, WriteData=12, {RegWrite,MemToReg,MemWrite}=001.
- Immediate operand: ALUControl=0010, ALUSrc=1, RegDst=0, ALUOp=0, value1=10, SignImm=100 -> AluOut=110, writeReg=1, controls=110, Zero=0.
- Subtract/zero: ALUControl=0110, ALUSrc=0, value1=value2=12, ALUOp=3 -> AluOut=0, Zero=1, controls=000.
- Signed vs unsigned compare: value1=0x80000000, value2=1 -> SLT gives 1, SLTU gives 0.
- Shifts: value1=4, value2=0xF0000000 -> SLL gives 0x00000000, SRL gives 0x0F000000, SRA gives 0xFF000000. Back-to-back ops on consecutive cycles produce one result per cycle with 1-cycle latency.
